regfile_wr_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources.
- Port 0 is the ALU/R-type result path; port 1 is the load/memory result path.
- Buffers one request per source, arbitrates round-robin, and issues one registered write per cycle.
- Drives the select of the 5-bit write-address mux and the matching data mux, so address, data and select always stay aligned.

---
 rtl/regfile_wr_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Purpose  : shares the register-file write port between the ALU (port 0) and load (port 1) writeback paths.
// Latency  : a request accepted at edge N is written after edge N+1 when uncontended; one write per cycle.
// Backpress: per-port ready = slot empty or slot granted this cycle; under contention ports alternate.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   req0_valid/ready/addr/data        port 0 (ALU/R-type result) request handshake
//   req1_valid/ready/addr/data        port 1 (load/memory result) request handshake
//   wr_en, wr_addr, wr_data           registered register-file write strobe, address and data
//   addr_sel                          registered write-mux select (0 = port 0, 1 = port 1)
//   busy                              high while either pending slot holds a request
//   conflict_cnt                      saturating count of contended cycles (ARB_CONFLICT_CNT_EN only)
//
// Optional build macro: ARB_CONFLICT_CNT_EN adds the conflict_cnt output and its counter.

module regfile_wr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,

    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              addr_sel,
    output logic              busy
`ifdef ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    // One buffered write request; address and data travel together so the
    // mux select, address and data can never drift apart.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dat;
    } wr_req_t;

    // Arbiter state: which port won the most recent grant.
    typedef enum logic {
        LG0 = 1'b0,
        LG1 = 1'b1
    } last_grant_t;

    last_grant_t last_grant;

    logic [1:0] pend_v;
    wr_req_t    pend [2];
    wr_req_t    req_in [2];

    logic       gnt_vld;
    logic       gnt_sel;
    logic [1:0] gnt;
    logic [1:0] rdy;
    logic [1:0] acc_vld;
    logic [1:0] store;

    // Gather the two request ports into indexable form.
    always_comb begin
        req_in[0].addr = req0_addr;
        req_in[0].dat  = req0_data;
        req_in[1].addr = req1_addr;
        req_in[1].dat  = req1_data;
    end

    // Grant depends on registered state only, which keeps ready free of any
    // combinational path from the request valids.
    always_comb begin
        gnt_vld = pend_v[0] | pend_v[1];
        if (pend_v == 2'b11) begin
            // Both waiting: hand the port to whoever did not win last time.
            gnt_sel = (last_grant == LG0);
        end else begin
            gnt_sel = pend_v[1];
        end
        gnt = 2'b00;
        if (gnt_vld) begin
            gnt[gnt_sel] = 1'b1;
        end
    end

    // A granted slot drains at this edge, so it can take a new request in the
    // same cycle; that is what gives one write per cycle from a single port.
    assign rdy        = ~pend_v | gnt;
    assign req0_ready = rdy[0];
    assign req1_ready = rdy[1];

    assign acc_vld = {req1_valid, req0_valid} & rdy;

    // Writes to r0 are handshaken normally but never buffered: r0 is hardwired
    // zero, so issuing them would only burn a write slot.
    assign store = acc_vld & {(|req1_addr), (|req0_addr)};

    assign busy = pend_v[0] | pend_v[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v     <= 2'b00;
            pend[0]    <= '0;
            pend[1]    <= '0;
            last_grant <= LG1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            addr_sel   <= 1'b0;
`ifdef ARB_CONFLICT_CNT_EN
            conflict_cnt <= 16'd0;
`endif
        end else begin
            // Slot update: a refill wins over the clear caused by the grant.
            for (int i = 0; i < 2; i++) begin
                if (store[i]) begin
                    pend_v[i] <= 1'b1;
                    pend[i]   <= req_in[i];
                end else if (gnt[i]) begin
                    pend_v[i] <= 1'b0;
                end
            end

            // Issue stage: address, data and select are all captured from the
            // same granted slot at the same edge.
            if (gnt_vld) begin
                wr_en      <= 1'b1;
                wr_addr    <= pend[gnt_sel].addr;
                wr_data    <= pend[gnt_sel].dat;
                addr_sel   <= gnt_sel;
                last_grant <= gnt_sel ? LG1 : LG0;
            end else begin
                // Idle: only the strobe drops; the mux inputs hold steady.
                wr_en <= 1'b0;
            end

`ifdef ARB_CONFLICT_CNT_EN
            if ((pend_v == 2'b11) && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Purpose  : directed self-checking bench for regfile_wr_arbiter.
// Latency  : inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpress: drives valids only; expected ready patterns come from hand-computed tables.

module tb_regfile_wr_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              addr_sel;
    logic              busy;
`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0]       conflict_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Contention scenario bookkeeping.
    int n0;
    int n1;
    int exp_addr [9] = '{0, 0, 10, 20, 11, 21, 12, 22, 13};
    int exp_sel  [9] = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
    logic exp_r0;
    logic exp_r1;

    regfile_wr_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .addr_sel   (addr_sel),
        .busy       (busy)
`ifdef ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_data  = '0;
        req1_data  = '0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check("rst_wr_en",    wr_en,      0);
        check("rst_wr_addr",  wr_addr,    0);
        check("rst_wr_data",  wr_data,    0);
        check("rst_addr_sel", addr_sel,   0);
        check("rst_busy",     busy,       0);
        check("rst_rdy0",     req0_ready, 1);
        check("rst_rdy1",     req1_ready, 1);
`ifdef ARB_CONFLICT_CNT_EN
        check("rst_cnt", conflict_cnt, 0);
`endif
        reset = 1'b0;

        // ---------------- port 0 streaming ----------------
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                req0_valid = 1'b1;
                req0_addr  = 5'(k + 1);
                req0_data  = 32'(32'hA1 + k);
                check("strm_rdy0", req0_ready, 1);
            end else begin
                req0_valid = 1'b0;
            end
            tick();
            if (k == 0) begin
                check("strm_first_idle", wr_en, 0);
            end else begin
                check("strm_wr_en",  wr_en,    1);
                check("strm_addr",   wr_addr,  32'(k));
                check("strm_data",   wr_data,  32'(32'hA0 + k));
                check("strm_sel",    addr_sel, 0);
            end
        end
        tick();
        check("strm_drain_en",   wr_en,   0);
        check("strm_hold_addr",  wr_addr, 3);
        check("strm_hold_data",  wr_data, 32'hA3);
        check("strm_busy",       busy,    0);

        // ---------------- simultaneous accept ----------------
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h55;
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("sim_idle_en", wr_en,      0);
        check("sim_busy0",   busy,       1);
        check("sim_rdy0",    req0_ready, 1);
        check("sim_rdy1",    req1_ready, 0);
        tick();
        check("sim_w1_en",   wr_en,      1);
        check("sim_w1_addr", wr_addr,    5);
        check("sim_w1_data", wr_data,    32'h55);
        check("sim_w1_sel",  addr_sel,   0);
        check("sim_busy1",   busy,       1);
        check("sim_rdy1b",   req1_ready, 1);
        tick();
        check("sim_w2_en",   wr_en,      1);
        check("sim_w2_addr", wr_addr,    9);
        check("sim_w2_data", wr_data,    32'h99);
        check("sim_w2_sel",  addr_sel,   1);
        check("sim_busy2",   busy,       0);
        tick();
        check("sim_end_en",  wr_en,      0);

        // ---------------- sustained contention ----------------
        do_reset();
        n0 = 0;
        n1 = 0;
        for (int k = 1; k <= 9; k++) begin
            exp_r0 = (k == 1) || (k % 2 == 0);
            exp_r1 = (k == 1) || (k % 2 == 1);
            if (k <= 6) begin
                req0_valid = 1'b1;
                req0_addr  = 5'(10 + n0);
                req0_data  = 32'(32'h1000 + 10 + n0);
                req1_valid = 1'b1;
                req1_addr  = 5'(20 + n1);
                req1_data  = 32'(32'h1000 + 20 + n1);
                check("cont_rdy0", req0_ready, 32'(exp_r0));
                check("cont_rdy1", req1_ready, 32'(exp_r1));
            end else begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
            if (k <= 6 && exp_r0) n0++;
            if (k <= 6 && exp_r1) n1++;
            if (k >= 2 && k <= 8) begin
                check("cont_en",   wr_en,    1);
                check("cont_addr", wr_addr,  32'(exp_addr[k]));
                check("cont_data", wr_data,  32'(32'h1000 + exp_addr[k]));
                check("cont_sel",  addr_sel, 32'(exp_sel[k]));
            end else begin
                check("cont_idle", wr_en, 0);
            end
`ifdef ARB_CONFLICT_CNT_EN
            check("cont_cnt", conflict_cnt, 32'((k - 1 < 6) ? (k - 1) : 6));
`endif
        end

        // ---------------- register 0 drop ----------------
        do_reset();
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD;
        check("r0_rdy1", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        check("r0_busy_a", busy,  0);
        check("r0_en_a",   wr_en, 0);
        tick();
        check("r0_busy_b", busy,  0);
        check("r0_en_b",   wr_en, 0);
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
        tick();
        req1_valid = 1'b0;
        check("r7_busy", busy,  1);
        check("r7_idle", wr_en, 0);
        tick();
        check("r7_en",   wr_en,    1);
        check("r7_addr", wr_addr,  7);
        check("r7_data", wr_data,  32'h77);
        check("r7_sel",  addr_sel, 1);

        // ---------------- reset mid-stream ----------------
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd3;  req0_data = 32'h33;
        req1_valid = 1'b1; req1_addr = 5'd4;  req1_data = 32'h44;
        tick();
        req0_addr = 5'd13; req0_data = 32'h133;
        req1_addr = 5'd14; req1_data = 32'h144;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("mid_full", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_en",   wr_en,      0);
        check("mid_rst_busy", busy,       0);
        check("mid_rst_sel",  addr_sel,   0);
        check("mid_rst_rdy0", req0_ready, 1);
        check("mid_rst_rdy1", req1_ready, 1);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mid_no_write", wr_en, 0);
        end

`ifdef ARB_CONFLICT_CNT_EN
        // ---------------- counter saturation ----------------
        do_reset();
        req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1;
        req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2;
        for (int k = 1; k <= 101; k++) tick();
        check("sat_mid", conflict_cnt, 100);
        for (int k = 102; k <= 65540; k++) tick();
        check("sat_full", conflict_cnt, 32'hFFFF);
        tick();
        check("sat_hold", conflict_cnt, 32'hFFFF);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
